// File: rtl/adder_result_stage.sv
// Registered result stage for an adder: captures sum, carry and derived flags
// behind a two-entry (output + skid) valid/ready buffer, and counts accepted results.
module adder_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_cout,
  input  logic             i_a_msb,
  input  logic             i_b_msb,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam int unsigned WW = WIDTH + 4;

  logic [1:0]    state;
  logic [WW-1:0] in_word;
  logic [WW-1:0] out_word;
  logic [WW-1:0] skid_word;
  logic          in_zero;
  logic          in_neg;
  logic          in_ovf;
  logic          up;
  logic          dn;

  // Word layout: {result, carry, zero, neg, ovf}
  assign in_zero = (i_result == '0);
  assign in_neg  = i_result[WIDTH-1];
  assign in_ovf  = (i_a_msb == i_b_msb) && (i_result[WIDTH-1] != i_a_msb);
  assign in_word = {i_result, i_cout, in_zero, in_neg, in_ovf};

  assign up = i_valid && o_ready;
  assign dn = o_valid && i_ready;

  assign o_valid = (state != EMPTY);
  assign {o_result, o_carry, o_zero, o_neg, o_ovf} = out_word;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= EMPTY;
      out_word  <= '0;
      skid_word <= '0;
      o_ready   <= 1'b1;
      o_count   <= '0;
    end else begin
      if (up) o_count <= o_count + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (up) begin
            out_word <= in_word;
            state    <= ONE;
          end
        end
        ONE: begin
          if (up && dn) begin
            out_word <= in_word;
          end else if (up) begin
            skid_word <= in_word;
            state     <= FULL;
            o_ready   <= 1'b0;
          end else if (dn) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // o_ready is low here, so only a drain can occur
          if (dn) begin
            out_word <= skid_word;
            state    <= ONE;
            o_ready  <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: scoreboarded flow tests plus
// flag, backpressure, counter-wrap and reset scenarios.
module tb_adder_result_stage;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_result;
  logic        i_cout;
  logic        i_a_msb;
  logic        i_b_msb;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_carry;
  logic        o_zero;
  logic        o_neg;
  logic        o_ovf;
  logic [15:0] o_count;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [35:0] sb[$];

  adder_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_result(i_result),
    .i_cout  (i_cout),
    .i_a_msb (i_a_msb),
    .i_b_msb (i_b_msb),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_carry (o_carry),
    .o_zero  (o_zero),
    .o_neg   (o_neg),
    .o_ovf   (o_ovf),
    .o_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] expect_word(logic [31:0] res, logic cout, logic am, logic bm);
    logic ovf;
    ovf = (am == bm) && (res[31] != am);
    return {res, cout, (res == 32'd0), res[31], ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0; i_result = 32'h1234_5678; i_cout = 1'b1;
    i_a_msb = 1'b1; i_b_msb = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_ready, o_result, o_carry, o_zero, o_neg, o_ovf, o_count} !== {1'b0, 1'b1, 52'd0}) begin
      $display("FAIL reset_state: got valid=%b ready=%b result=%h c/z/n/o=%b%b%b%b count=%0d, expected 0 1 00000000 0000 0",
               o_valid, o_ready, o_result, o_carry, o_zero, o_neg, o_ovf, o_count);
    end else passes++;
    rst = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_flags();
    i_valid = 1'b1; i_ready = 1'b1; i_result = 32'h0; i_cout = 1'b1; i_a_msb = 1'b0; i_b_msb = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_result, o_zero, o_carry, o_neg, o_ovf, o_count} !== {1'b1, 32'h0, 4'b1100, 16'd1}) begin
      $display("FAIL zero_carry: got valid=%b result=%h z=%b c=%b n=%b o=%b count=%0d, expected 1 00000000 1 1 0 0 1",
               o_valid, o_result, o_zero, o_carry, o_neg, o_ovf, o_count);
    end else passes++;
    i_result = 32'h8000_0000; i_cout = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_result, o_zero, o_carry, o_neg, o_ovf, o_count} !== {1'b1, 32'h8000_0000, 4'b0011, 16'd2}) begin
      $display("FAIL neg_ovf: got valid=%b result=%h z=%b c=%b n=%b o=%b count=%0d, expected 1 80000000 0 0 1 1 2",
               o_valid, o_result, o_zero, o_carry, o_neg, o_ovf, o_count);
    end else passes++;
    i_valid = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_result, o_neg, o_ovf} !== {1'b0, 32'h8000_0000, 2'b11}) begin
      $display("FAIL hold_when_idle: got valid=%b result=%h n=%b o=%b, expected 0 80000000 1 1",
               o_valid, o_result, o_neg, o_ovf);
    end else passes++;
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    logic [35:0] exp_w;
    do_reset();
    base = 16'd0;
    i_ready = 1'b0; i_valid = 1'b1; i_cout = 1'b0; i_a_msb = 1'b0; i_b_msb = 1'b0;
    i_result = 32'd5;
    sb.push_back(expect_word(32'd5, 1'b0, 1'b0, 1'b0));
    tick();
    i_result = 32'd7;
    sb.push_back(expect_word(32'd7, 1'b0, 1'b0, 1'b0));
    tick();
    checks++;
    if ({o_valid, o_ready, o_result} !== {1'b1, 1'b0, 32'd5}) begin
      $display("FAIL bp_full: got valid=%b ready=%b result=%0d, expected 1 0 5", o_valid, o_ready, o_result);
    end else passes++;
    i_result = 32'd9;
    tick();
    checks++;
    if ({o_ready, o_result, o_count} !== {1'b0, 32'd5, base + 16'd2}) begin
      $display("FAIL bp_refuse: got ready=%b result=%0d count=%0d, expected 0 5 %0d", o_ready, o_result, o_count, base + 16'd2);
    end else passes++;
    i_ready = 1'b1;
    exp_w = sb.pop_front();
    checks++;
    if ({o_result, o_carry, o_zero, o_neg, o_ovf} !== exp_w) begin
      $display("FAIL bp_first_out: got %h, expected %h", {o_result, o_carry, o_zero, o_neg, o_ovf}, exp_w);
    end else passes++;
    tick();
    checks++;
    if ({o_valid, o_ready} !== 2'b11) begin
      $display("FAIL bp_reopen: got valid=%b ready=%b, expected 1 1", o_valid, o_ready);
    end else passes++;
    sb.push_back(expect_word(32'd9, 1'b0, 1'b0, 1'b0));
    exp_w = sb.pop_front();
    checks++;
    if ({o_result, o_carry, o_zero, o_neg, o_ovf} !== exp_w) begin
      $display("FAIL bp_second_out: got %h, expected %h", {o_result, o_carry, o_zero, o_neg, o_ovf}, exp_w);
    end else passes++;
    tick();
    i_valid = 1'b0;
    exp_w = sb.pop_front();
    checks++;
    if ({o_valid, o_result, o_carry, o_zero, o_neg, o_ovf} !== {1'b1, exp_w}) begin
      $display("FAIL bp_third_out: got valid=%b %h, expected 1 %h", o_valid, {o_result, o_carry, o_zero, o_neg, o_ovf}, exp_w);
    end else passes++;
    tick();
    checks++;
    if ({o_valid, o_count} !== {1'b0, base + 16'd3}) begin
      $display("FAIL bp_drain: got valid=%b count=%0d, expected 0 %0d", o_valid, o_count, base + 16'd3);
    end else passes++;
  endtask

  task automatic test_back_to_back();
    int unsigned sent = 0;
    int unsigned got = 0;
    int unsigned cyc = 0;
    int unsigned bad = 0;
    logic [31:0] a, b;
    logic [32:0] s;
    logic [35:0] exp_w;
    do_reset();
    sb.delete();
    i_ready = 1'b1;
    while (cyc < 300 && (sent < 100 || sb.size() > 0)) begin
      if (sent < 100) begin
        a = $urandom_range(99, 0);
        b = $urandom_range(99, 0);
        s = {1'b0, a} + {1'b0, b};
        i_valid = 1'b1; i_result = s[31:0]; i_cout = s[32]; i_a_msb = a[31]; i_b_msb = b[31];
      end else begin
        i_valid = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL b2b_spurious: got unexpected word %h, expected none", o_result);
        end else begin
          exp_w = sb.pop_front();
          checks++;
          if ({o_result, o_carry, o_zero, o_neg, o_ovf} !== exp_w) begin
            $display("FAIL b2b_data[%0d]: got %h, expected %h", got, {o_result, o_carry, o_zero, o_neg, o_ovf}, exp_w);
          end else passes++;
          got++;
        end
      end else if (cyc > 0 && sb.size() > 0) begin
        bad++;
      end
      if (i_valid && o_ready) begin
        sb.push_back(expect_word(i_result, i_cout, i_a_msb, i_b_msb));
        sent++;
      end
      tick();
      cyc++;
    end
    checks++;
    if ({got, cyc, bad} !== {32'd100, 32'd101, 32'd0}) begin
      $display("FAIL b2b_rate: got words=%0d cycles=%0d gaps=%0d, expected 100 101 0", got, cyc, bad);
    end else passes++;
    checks++;
    if (o_count !== 16'd100) begin
      $display("FAIL b2b_count: got %0d, expected 100", o_count);
    end else passes++;
  endtask

  task automatic test_count_wrap();
    do_reset();
    i_valid = 1'b1; i_ready = 1'b1; i_result = 32'd1; i_cout = 1'b0; i_a_msb = 1'b0; i_b_msb = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    checks++;
    if (o_count !== 16'hFFFF) begin
      $display("FAIL count_max: got %0d, expected 65535", o_count);
    end else passes++;
    tick();
    checks++;
    if (o_count !== 16'd0) begin
      $display("FAIL count_wrap: got %0d, expected 0", o_count);
    end else passes++;
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_full();
    int unsigned stale = 0;
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_result = 32'hDEAD_BEEF; i_cout = 1'b1; i_a_msb = 1'b1; i_b_msb = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_valid, o_ready} !== 2'b10) begin
      $display("FAIL rf_fill: got valid=%b ready=%b, expected 1 0", o_valid, o_ready);
    end else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({o_valid, o_ready, o_count, o_result} !== {1'b0, 1'b1, 16'd0, 32'd0}) begin
      $display("FAIL rf_reset: got valid=%b ready=%b count=%0d result=%h, expected 0 1 0 00000000",
               o_valid, o_ready, o_count, o_result);
    end else passes++;
    i_valid = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      $display("FAIL rf_stale: got %0d stale valid cycles, expected 0", stale);
    end else passes++;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_result = '0; i_cout = 1'b0;
    i_a_msb = 1'b0; i_b_msb = 1'b0;
    test_reset();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_count_wrap();
    test_reset_full();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
